// File: rtl/mvm_uart_pkg.sv
// mvm_uart_pkg: shared bus sizing, state encodings and sizing helpers for the MVM UART host.
// Ports: none. The default-configuration bus sizes (R=C=8, 8-bit K/X, 32-bit Y) are provided here.
// Optional feature macro used by the design files: UART_FRAME_ERR_EN.
package mvm_uart_pkg;

  // Bus sizes for the default configuration.
  localparam int W_BUS_KX = 8*8*8 + 8*8;
  localparam int W_BUS_Y  = 8*32;
  localparam int N_KX     = W_BUS_KX / 8;
  localparam int N_Y      = W_BUS_Y / 8;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int kx_bus_width(input int r, input int c, input int w_x, input int w_k);
    return r*c*w_k + c*w_x;
  endfunction

  function automatic int y_bus_width(input int r, input int w_y);
    return r*w_y;
  endfunction

endpackage

// File: rtl/mvm_uart_host_if.sv
// mvm_uart_host_if: operand (s_*) and result (m_*) valid/ready buses of the MVM UART host.
// Ports: s_valid/s_ready/s_data carry K/X operands in; m_valid/m_ready/m_data carry Y results out.
// Modports: slave = the host block itself, master = whoever drives operands and consumes results.
interface mvm_uart_host_if
  import mvm_uart_pkg::*;
#(
  parameter int W_S = W_BUS_KX,
  parameter int W_M = W_BUS_Y
);
  logic           s_valid;
  logic           s_ready;
  logic [W_S-1:0] s_data;
  logic           m_valid;
  logic           m_ready;
  logic [W_M-1:0] m_data;

  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data);
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 2-flop synchroniser plus UART receive FSM (start-centre qualify, LSB-first data, one stop sample).
// Latency: byte_valid pulses one cycle after the stop-bit centre. No backpressure: every completed frame is reported.
// Ports: clk, rst (async high), rx (async line in), data (last byte), byte_valid / stop_err (1-cycle pulses).
// Macro UART_FRAME_ERR_EN: when defined, a low stop-bit sample raises stop_err; otherwise stop_err stays 0.
module uart_frame_rx
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 200_000_000/9600,
  parameter int BITS_PER_WORD    = 8
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] data,
  output logic                     byte_valid,
  output logic                     stop_err
);
  localparam int CW   = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int BW   = $clog2(BITS_PER_WORD + 1);
  localparam int HALF = (CLOCKS_PER_PULSE/2 > 0) ? CLOCKS_PER_PULSE/2 : 1;

  logic [1:0]    sync_q;
  logic          rx_s, rx_prev_q;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic          half_end, full_end;

  assign rx_s     = sync_q[1];
  assign half_end = (cnt_q == CW'(HALF - 1));
  assign full_end = (cnt_q == CW'(CLOCKS_PER_PULSE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // A new frame needs a real 1->0 edge, so after a bad stop bit the FSM only
  // re-arms once the line has gone back high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (rx_prev_q && !rx_s) state_d = RX_START;
      RX_START: if (half_end) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_end && bit_q == BW'(BITS_PER_WORD - 1)) state_d = RX_STOP;
      RX_STOP:  if (full_end) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      rx_prev_q  <= rx_s;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
        end
        RX_START: cnt_q <= half_end ? '0 : cnt_q + 1'b1;
        RX_DATA: begin
          if (full_end) begin
            cnt_q <= '0;
            data  <= {rx_s, data[BITS_PER_WORD-1:1]};
            bit_q <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (full_end) begin
            cnt_q      <= '0;
            byte_valid <= 1'b1;
`ifdef UART_FRAME_ERR_EN
            stop_err   <= !rx_s;
`else
            stop_err   <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: rtl/mvm_uart_host.sv
// mvm_uart_host: serialises the K/X operand bus onto tx as UART frames and gathers Y result bytes from rx.
// Latency: s_ready returns N_KX*PACKET_SIZE_TX*CLOCKS_PER_PULSE cycles after accept; m_valid one cycle after last byte.
// Backpressure: s_ready low while sending; result held until m_ready, bytes arriving meanwhile are dropped with overrun.
// Ports: clk, rst (async high), bus (mvm_uart_host_if.slave), tx, rx, overrun, frame_err. Macro: UART_FRAME_ERR_EN.
module mvm_uart_host
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 200_000_000/9600,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = BITS_PER_WORD + 5,
  parameter int W_Y_OUT          = 32,
  parameter int R                = 8,
  parameter int C                = 8,
  parameter int W_X              = 8,
  parameter int W_K              = 8
)(
  input  logic            clk,
  input  logic            rst,
  mvm_uart_host_if.slave  bus,
  output logic            tx,
  input  logic            rx,
  output logic            overrun,
  output logic            frame_err
);
  localparam int KX_W     = kx_bus_width(R, C, W_X, W_K);
  localparam int Y_W      = y_bus_width(R, W_Y_OUT);
  localparam int KX_WORDS = KX_W / BITS_PER_WORD;
  localparam int Y_WORDS  = Y_W / BITS_PER_WORD;
  localparam int CW       = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int PW       = $clog2(PACKET_SIZE_TX + 1);
  localparam int KW       = $clog2(KX_WORDS + 1);
  localparam int YW       = $clog2(Y_WORDS + 1);
  localparam int BI       = $clog2(BITS_PER_WORD);

  if ((KX_W % BITS_PER_WORD) != 0 || (Y_W % BITS_PER_WORD) != 0) begin : g_bad_width
    $error("mvm_uart_host: bus widths must be multiples of BITS_PER_WORD");
  end

  // ---------------- TX ----------------
  tx_state_t               tx_state_q, tx_state_d;
  logic [KX_W-1:0]         shreg_q;
  logic [BITS_PER_WORD-1:0] cur_word;
  logic [CW-1:0]           clk_cnt_q;
  logic [PW-1:0]           bit_cnt_q;
  logic [KW-1:0]           word_cnt_q;
  logic                    tx_q, pulse_end, bit_end, word_end;

  assign cur_word    = shreg_q[BITS_PER_WORD-1:0];
  assign pulse_end   = (clk_cnt_q == CW'(CLOCKS_PER_PULSE - 1));
  assign bit_end     = (bit_cnt_q == PW'(PACKET_SIZE_TX - 1));
  assign word_end    = (word_cnt_q == KW'(KX_WORDS - 1));
  assign bus.s_ready = (tx_state_q == TX_IDLE);
  assign tx          = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state_q <= TX_IDLE;
    else     tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if (bus.s_valid) tx_state_d = TX_SEND;
      TX_SEND: if (pulse_end && bit_end && word_end) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // tx_q is loaded one bit-time ahead: at the end of bit-time n it takes the
  // value for bit-time n+1 (0 = start, 1..BITS_PER_WORD = data, rest = stop).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q       <= 1'b1;
      shreg_q    <= '0;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else if (tx_state_q == TX_IDLE) begin
      if (bus.s_valid) begin
        shreg_q    <= bus.s_data;
        tx_q       <= 1'b0;
        clk_cnt_q  <= '0;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
      end
    end else if (pulse_end) begin
      clk_cnt_q <= '0;
      if (bit_end) begin
        bit_cnt_q  <= '0;
        shreg_q    <= shreg_q >> BITS_PER_WORD;
        word_cnt_q <= word_cnt_q + 1'b1;
        tx_q       <= word_end;
      end else begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        tx_q      <= (bit_cnt_q < PW'(BITS_PER_WORD)) ? cur_word[bit_cnt_q[BI-1:0]] : 1'b1;
      end
    end else begin
      clk_cnt_q <= clk_cnt_q + 1'b1;
    end
  end

  // ---------------- RX ----------------
  logic [BITS_PER_WORD-1:0] rx_byte;
  logic                     byte_valid, stop_err, byte_ok;
  logic [Y_W-1:0]           acc_q, acc_d, m_data_q;
  logic [YW-1:0]            cnt_q;
  logic                     m_valid_q, overrun_q;

  uart_frame_rx #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
    .BITS_PER_WORD    (BITS_PER_WORD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (rx_byte),
    .byte_valid (byte_valid),
    .stop_err   (stop_err)
  );

  assign byte_ok     = byte_valid && !stop_err;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign overrun     = overrun_q;

  // Accumulator with the incoming byte dropped into slot cnt_q.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < Y_WORDS; i++) begin
      if (cnt_q == YW'(i)) acc_d[i*BITS_PER_WORD +: BITS_PER_WORD] = rx_byte;
    end
  end

  // A byte landing in the same cycle as the result handshake is kept:
  // the holding register frees up on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;
      if (byte_ok) begin
        if (m_valid_q && !bus.m_ready) begin
          overrun_q <= 1'b1;
        end else if (cnt_q == YW'(Y_WORDS - 1)) begin
          m_data_q  <= acc_d;
          m_valid_q <= 1'b1;
          cnt_q     <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef UART_FRAME_ERR_EN
  logic frame_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= byte_valid && stop_err;
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_uart_host.sv
// tb_mvm_uart_host: randomized self-checking bench for mvm_uart_host (CLOCKS_PER_PULSE=4, R=C=2, 8-bit K/X).
// Drives operand handshakes and UART frames, decodes tx and collects results against a byte-level model.
// Ports: none (top-level bench). Honours UART_FRAME_ERR_EN for the stop-bit scenario.
module tb_mvm_uart_host;
  localparam int CPP   = 4;
  localparam int BPW   = 8;
  localparam int PKT   = BPW + 5;
  localparam int R     = 2;
  localparam int C     = 2;
  localparam int W_X   = 8;
  localparam int W_K   = 8;
  localparam int W_Y   = 32;
  localparam int W_KX  = R*C*W_K + C*W_X;
  localparam int W_YB  = R*W_Y;
  localparam int N_KX  = W_KX / BPW;
  localparam int N_Y   = W_YB / BPW;
  localparam int FRAME = PKT * CPP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx, overrun, frame_err;

  mvm_uart_host_if #(.W_S(W_KX), .W_M(W_YB)) bus ();

  mvm_uart_host #(
    .CLOCKS_PER_PULSE (CPP), .BITS_PER_WORD (BPW), .PACKET_SIZE_TX (PKT),
    .W_Y_OUT (W_Y), .R (R), .C (C), .W_X (W_X), .W_K (W_K)
  ) dut (
    .clk (clk), .rst (rst), .bus (bus), .tx (tx), .rx (rx),
    .overrun (overrun), .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result/flag monitor.
  logic [63:0] got_q[$];
  int mv_cycles = 0, ovr_cnt = 0, fe_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
      if (bus.m_valid) mv_cycles++;
      if (overrun)     ovr_cnt++;
      if (frame_err)   fe_cnt++;
    end
  end

  function automatic logic [63:0] pack_bytes(input logic [7:0] b [8]);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = b[i];
    return r;
  endfunction

  task automatic rand_bytes(output logic [7:0] b [8]);
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
  endtask

  // One UART frame on rx: start, 8 data LSB first, stop_bit, then 3 idle bit-times.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPP) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPP) @(negedge clk);
    rx = 1'b1;
    repeat ((PKT - BPW - 2) * CPP) @(negedge clk);
  endtask

  task automatic rx_set(input logic [7:0] b [8]);
    for (int i = 0; i < 8; i++) rx_frame(b[i], 1'b1);
  endtask

  task automatic expect_result(input string tag, input logic [63:0] exp);
    int w;
    w = 0;
    while (got_q.size() == 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_avail"}, 64'(got_q.size() != 0), 64'd1);
    if (got_q.size() != 0) check(tag, got_q.pop_front(), exp);
  endtask

  // Handshake one operand bus and decode the whole tx waveform.
  task automatic send_tx(input logic [47:0] d);
    logic       t [N_KX*FRAME];
    logic [7:0] got;
    logic       e;
    int         w, low_cnt, bad;
    w = 0;
    while (!bus.s_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("tx_ready_wait", 64'(bus.s_ready), 64'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    @(negedge clk);
    bus.s_valid = 1'b0;
    low_cnt = 0;
    for (int k = 0; k < N_KX*FRAME; k++) begin
      t[k] = tx;
      if (!bus.s_ready) low_cnt++;
      @(negedge clk);
    end
    check("s_ready_low_cycles", 64'(low_cnt), 64'(N_KX*FRAME));
    check("s_ready_back", 64'(bus.s_ready), 64'd1);
    for (int wd = 0; wd < N_KX; wd++) begin
      bad = 0;
      for (int bt = 0; bt < PKT; bt++) begin
        if (bt == 0)        e = 1'b0;
        else if (bt <= BPW) e = d[wd*8 + bt - 1];
        else                e = 1'b1;
        for (int c = 0; c < CPP; c++) if (t[wd*FRAME + bt*CPP + c] !== e) bad++;
      end
      for (int j = 0; j < 8; j++) got[j] = t[wd*FRAME + (1+j)*CPP + CPP/2];
      check("tx_byte", 64'(got), 64'(d[wd*8 +: 8]));
      check("tx_frame_shape", 64'(bad), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b [8];
    logic [7:0]  b2 [8];
    logic [7:0]  bad_byte;
    logic [63:0] tmp, e;
    int m0, o0, f0;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_s_ready", 64'(bus.s_ready), 64'd1);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_data", bus.m_data, 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Fixed TX frame check.
    send_tx(48'h0605_0403_0201);

    // Fixed RX result.
    b = '{8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'h05, 8'h00, 8'h00, 8'h00};
    m0 = mv_cycles;
    rx_set(b);
    repeat (4) @(negedge clk);
    expect_result("rx_fixed", 64'h0000_0005_FFFF_FFF0);
    check("rx_m_valid_pulse", 64'(mv_cycles - m0), 64'd1);

    // Random TX and RX running at the same time.
    for (int k = 0; k < 3; k++) begin
      rand_bytes(b);
      tmp = {$urandom, $urandom};
      fork
        send_tx(tmp[47:0]);
        rx_set(b);
      join
      repeat (4) @(negedge clk);
      expect_result("rx_rand", pack_bytes(b));
    end
    check("no_overrun_yet", 64'(ovr_cnt), 64'd0);

    // Backpressure and overrun.
    @(posedge clk); #1 bus.m_ready = 1'b0;
    @(negedge clk);
    rand_bytes(b);
    rx_set(b);
    repeat (4) @(negedge clk);
    check("bp_m_valid", 64'(bus.m_valid), 64'd1);
    check("bp_m_data", bus.m_data, pack_bytes(b));
    o0 = ovr_cnt;
    rx_frame(8'hAA, 1'b1);
    repeat (4) @(negedge clk);
    check("overrun_pulses", 64'(ovr_cnt - o0), 64'd1);
    check("bp_data_hold", bus.m_data, pack_bytes(b));
    check("bp_valid_hold", 64'(bus.m_valid), 64'd1);
    @(posedge clk); #1 bus.m_ready = 1'b1;
    @(negedge clk);
    expect_result("bp_first", pack_bytes(b));
    check("bp_m_valid_clr", 64'(bus.m_valid), 64'd0);
    rand_bytes(b2);
    rx_set(b2);
    repeat (4) @(negedge clk);
    expect_result("bp_second", pack_bytes(b2));

    // Glitch rejection.
    o0 = ovr_cnt; f0 = fe_cnt; m0 = mv_cycles;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_result", 64'(mv_cycles - m0), 64'd0);
    check("glitch_flags", 64'((ovr_cnt - o0) + (fe_cnt - f0)), 64'd0);
    rand_bytes(b);
    rx_set(b);
    repeat (4) @(negedge clk);
    expect_result("post_glitch", pack_bytes(b));

    // Stop bit sampled low.
    bad_byte = 8'($urandom);
    f0 = fe_cnt;
    rx_frame(bad_byte, 1'b0);
    rand_bytes(b);
    rx_set(b);
    repeat (4) @(negedge clk);
`ifdef UART_FRAME_ERR_EN
    check("frame_err_pulse", 64'(fe_cnt - f0), 64'd1);
    expect_result("fe_result", pack_bytes(b));
`else
    check("frame_err_off", 64'(fe_cnt - f0), 64'd0);
    e = '0;
    e[7:0] = bad_byte;
    for (int i = 1; i < 8; i++) e[i*8 +: 8] = b[i-1];
    expect_result("fe_counted", e);
`endif

    // Reset during TX word 3.
    tmp = {$urandom, $urandom};
    bus.s_valid = 1'b1;
    bus.s_data  = tmp[47:0];
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (3*FRAME + 1) @(negedge clk);
    check("pre_rst_tx_start", 64'(tx), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tx", 64'(tx), 64'd1);
    check("rst_mid_s_ready", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_tx_idle", 64'(tx), 64'd1);

    // Reset after 5 RX bytes.
    rand_bytes(b);
    for (int i = 0; i < 5; i++) rx_frame(b[i], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_m_valid", 64'(bus.m_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    got_q.delete();
    m0 = mv_cycles;
    rand_bytes(b);
    rx_set(b);
    repeat (4) @(negedge clk);
    check("post_rst_valid_count", 64'(mv_cycles - m0), 64'd1);
    expect_result("post_rst_data", pack_bytes(b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
